aes_key_expander: RTL

Iterative AES key-schedule engine supporting AES-128, AES-192 and AES-256. It expands one 32-bit schedule word per cycle into an internal round-key store. The S-box is shared and external: the block drives sbox_feed and receives new_sbox combinationally. The cipher datapath reads round keys by index through a registered read port.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_key_expander_if.sv | 34 +++
 rtl/aes_key_word_store.sv | 43 ++++
 rtl/aes_key_expander.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES key-schedule engine.
package aes_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned KEY_W     = 256;
   localparam int unsigned MAX_WORDS = 60;
   localparam int unsigned ADDR_W    = 6;

   typedef enum logic [1:0] {
      KL128 = 2'b00,
      KL192 = 2'b01,
      KL256 = 2'b10,
      KLRSV = 2'b11
   } key_len_e;

   typedef logic [127:0] round_key_t;

   function automatic logic [3:0] nk(input key_len_e kl);
      case (kl)
         KL192:   return 4'd6;
         KL256:   return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr(input key_len_e kl);
      case (kl)
         KL192:   return 4'd12;
         KL256:   return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key offer, status, S-box and round-key read signals of the key expander.
interface aes_key_expander_if;
   import aes_pkg::*;

   logic [KEY_W-1:0]  key_in;
   logic [1:0]        key_len;
   logic              key_valid;
   logic              key_ready;
   logic              busy;
   logic              done;
   logic              keys_valid;
   logic [3:0]        num_rounds;
   logic              err;
   logic [WORD_W-1:0] sbox_feed;
   logic [WORD_W-1:0] new_sbox;
   logic              rd_en;
   logic [3:0]        rd_round;
   round_key_t        rd_key;
   logic              rd_valid;
   logic              rd_oob;

   modport slave (
      input  key_in, key_len, key_valid, new_sbox, rd_en, rd_round,
      output key_ready, busy, done, keys_valid, num_rounds, err, sbox_feed,
             rd_key, rd_valid, rd_oob
   );

   modport master (
      output key_in, key_len, key_valid, new_sbox, rd_en, rd_round,
      input  key_ready, busy, done, keys_valid, num_rounds, err, sbox_feed,
             rd_key, rd_valid, rd_oob
   );

endinterface

// File: rtl/aes_key_word_store.sv
// Round-key word array: Nk-word parallel load, single-word write, 4-word registered read.
module aes_key_word_store
   import aes_pkg::*;
#(
   parameter int unsigned DEPTH = MAX_WORDS
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              load_en,
   input  logic [3:0]        load_nk,
   input  logic [KEY_W-1:0]  load_key,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_hit,
   input  logic [3:0]        rd_round,
   output round_key_t        rd_key
);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] rd_base;

   assign rd_base = {rd_round, 2'b00};

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int n = 0; n < int'(DEPTH); n++) mem[n] <= '0;
         rd_key <= '0;
      end else begin
         if (load_en) begin
            for (int n = 0; n < 8; n++)
               if (n < int'(load_nk)) mem[n] <= load_key[KEY_W-1-32*n -: 32];
         end
         if (wr_en) mem[wr_addr] <= wr_data;
         // Out-of-range reads never index the array; they return zero.
         if (rd_en)
            rd_key <= rd_hit ? {mem[rd_base], mem[rd_base + 6'd1],
                                mem[rd_base + 6'd2], mem[rd_base + 6'd3]} : '0;
      end
   end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule, one word per cycle, with an external shared S-box.
module aes_key_expander
   import aes_pkg::*;
#(
   parameter bit SUPPORT_192 = 1'b1,
   parameter bit SUPPORT_256 = 1'b1
) (
   input  logic               aclk,
   input  logic               aresetn,
   aes_key_expander_if.slave  bus
);

   localparam int unsigned DEPTH = SUPPORT_256 ? MAX_WORDS : 52;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_EXPAND = 2'b01;
   localparam logic [1:0] ST_READY  = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [2:0]        phase_q, phase_d;
   logic [7:0]        rcon_q, rcon_d;
   logic [KEY_W-1:0]  win_q, win_d;
   logic [3:0]        nk_q, nk_d, nr_q, nr_d;
   logic              key_ready_q, key_ready_d, busy_q, busy_d, done_q, done_d;
   logic              keys_valid_q, keys_valid_d, err_q, err_d;
   logic [3:0]        num_rounds_q, num_rounds_d;
   logic [WORD_W-1:0] sbox_feed_q, sbox_feed_d;
   logic              rd_valid_q, rd_oob_q;

   key_len_e          kl;
   logic              kl_legal, accept, load_en, wr_en, rd_hit;
   logic [ADDR_W-1:0] tot;
   logic [WORD_W-1:0] w_prev, w_old, t_word, w_new;

   assign kl     = key_len_e'(bus.key_len);
   assign accept = bus.key_valid && key_ready_q;
   assign tot    = ADDR_W'({nr_q, 2'b00}) + ADDR_W'(4);
   assign rd_hit = keys_valid_q && (bus.rd_round <= num_rounds_q);

   always_comb begin
      kl_legal = 1'b0;
      case (kl)
         KL128:   kl_legal = 1'b1;
         KL192:   kl_legal = SUPPORT_192;
         KL256:   kl_legal = SUPPORT_256;
         default: kl_legal = 1'b0;
      endcase
   end

   // win_q[31:0] is w[i-1]; w[i-Nk] sits Nk-1 words above it.
   always_comb begin
      w_prev = win_q[31:0];
      case (nk_q)
         4'd4:    w_old = win_q[127:96];
         4'd6:    w_old = win_q[191:160];
         default: w_old = win_q[255:224];
      endcase
      if (phase_q == 3'd0)
         t_word = bus.new_sbox ^ {rcon_q, 24'h0};
      else if (nk_q == 4'd8 && phase_q == 3'd4)
         t_word = bus.new_sbox;
      else
         t_word = w_prev;
      w_new = w_old ^ t_word;
   end

   // Next-state and output logic; sbox_feed is prepared one cycle ahead of its use.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      phase_d      = phase_q;
      rcon_d       = rcon_q;
      win_d        = win_q;
      nk_d         = nk_q;
      nr_d         = nr_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      keys_valid_d = keys_valid_q;
      num_rounds_d = num_rounds_q;
      sbox_feed_d  = '0;
      load_en      = 1'b0;
      wr_en        = 1'b0;

      if (accept) begin
         keys_valid_d = 1'b0;
         num_rounds_d = 4'd0;
         if (kl_legal) begin
            load_en = 1'b1;
            state_d = ST_EXPAND;
            nk_d    = nk(kl);
            nr_d    = nr(kl);
            idx_d   = ADDR_W'(nk(kl));
            phase_d = 3'd0;
            rcon_d  = 8'h01;
            case (kl)
               KL128:   win_d = {128'h0, bus.key_in[255:128]};
               KL192:   win_d = {64'h0, bus.key_in[255:64]};
               default: win_d = bus.key_in;
            endcase
            sbox_feed_d = rot_word(win_d[31:0]);
         end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end
      end else if (state_q == ST_EXPAND) begin
         if (idx_q == tot) begin
            done_d       = 1'b1;
            keys_valid_d = 1'b1;
            num_rounds_d = nr_q;
            state_d      = ST_READY;
         end else begin
            wr_en   = 1'b1;
            win_d   = {win_q[KEY_W-WORD_W-1:0], w_new};
            idx_d   = idx_q + ADDR_W'(1);
            phase_d = (phase_q == 3'(nk_q - 4'd1)) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
            if (idx_d != tot) begin
               if (phase_d == 3'd0)
                  sbox_feed_d = rot_word(w_new);
               else if (nk_q == 4'd8 && phase_d == 3'd4)
                  sbox_feed_d = w_new;
            end
         end
      end

      key_ready_d = (state_d != ST_EXPAND);
      busy_d      = (state_d == ST_EXPAND);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         phase_q      <= '0;
         rcon_q       <= '0;
         win_q        <= '0;
         nk_q         <= '0;
         nr_q         <= '0;
         key_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         keys_valid_q <= 1'b0;
         err_q        <= 1'b0;
         num_rounds_q <= '0;
         sbox_feed_q  <= '0;
         rd_valid_q   <= 1'b0;
         rd_oob_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         phase_q      <= phase_d;
         rcon_q       <= rcon_d;
         win_q        <= win_d;
         nk_q         <= nk_d;
         nr_q         <= nr_d;
         key_ready_q  <= key_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         keys_valid_q <= keys_valid_d;
         err_q        <= err_d;
         num_rounds_q <= num_rounds_d;
         sbox_feed_q  <= sbox_feed_d;
         rd_valid_q   <= bus.rd_en;
         rd_oob_q     <= bus.rd_en && !rd_hit;
      end
   end

   aes_key_word_store #(.DEPTH(DEPTH)) u_store (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .load_en  (load_en),
      .load_nk  (nk(kl)),
      .load_key (bus.key_in),
      .wr_en    (wr_en),
      .wr_addr  (idx_q),
      .wr_data  (w_new),
      .rd_en    (bus.rd_en),
      .rd_hit   (rd_hit),
      .rd_round (bus.rd_round),
      .rd_key   (bus.rd_key)
   );

   assign bus.key_ready  = key_ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.keys_valid = keys_valid_q;
   assign bus.num_rounds = num_rounds_q;
   assign bus.err        = err_q;
   assign bus.sbox_feed  = sbox_feed_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_oob     = rd_oob_q;

endmodule
